// File: rtl/fifo_n_pkg.sv
// Shared sizing helpers for the fifo_n family (count and pointer widths).
package fifo_pkg;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int fifo_ptr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_n_if.sv
// Handshake bundle for fifo_n. OVERFLOW/UNDERFLOW exist only when FIFO_N_ERROR_CHECK_EN is defined.
interface fifo_n_if import fifo_pkg::*; #(
    parameter int width = 32,
    parameter int depth = 4
);
    localparam int cw = fifo_cnt_w(depth);

    // ENQ/DEQ are level strobes sampled on every rising CLK edge. An ENQ is accepted when
    // FULL_N=1, or while full if DEQ is also asserted; a DEQ is accepted when EMPTY_N=1.
    // CLR overrides both strobes for that edge.
    logic [width-1:0] D_IN;
    logic             ENQ;
    logic             FULL_N;
    logic             ALMOST_FULL_N;
    logic [width-1:0] D_OUT;
    logic             DEQ;
    logic             EMPTY_N;
    logic [cw-1:0]    COUNT;
    logic             CLR;
`ifdef FIFO_N_ERROR_CHECK_EN
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (output D_IN, ENQ, DEQ, CLR,
                    input  FULL_N, ALMOST_FULL_N, D_OUT, EMPTY_N, COUNT, OVERFLOW, UNDERFLOW);
    modport slave  (input  D_IN, ENQ, DEQ, CLR,
                    output FULL_N, ALMOST_FULL_N, D_OUT, EMPTY_N, COUNT, OVERFLOW, UNDERFLOW);
`else
    modport master (output D_IN, ENQ, DEQ, CLR,
                    input  FULL_N, ALMOST_FULL_N, D_OUT, EMPTY_N, COUNT);
    modport slave  (input  D_IN, ENQ, DEQ, CLR,
                    output FULL_N, ALMOST_FULL_N, D_OUT, EMPTY_N, COUNT);
`endif
endinterface

// File: rtl/fifo_n_ptr.sv
// Modulo-depth pointer: advances on inc, wraps depth-1 -> 0, clr returns it to 0.
module fifo_n_ptr import fifo_pkg::*; #(
    parameter int depth = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          inc,
    output logic [fifo_ptr_w(depth)-1:0]  ptr
);
    localparam int             pw   = fifo_ptr_w(depth);
    localparam logic [pw-1:0]  last = pw'(depth - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == last) ? '0 : ptr + pw'(1);
        end
    end

endmodule

// File: rtl/fifo_n.sv
// Depth-N synchronous FIFO with registered show-ahead head, occupancy count and almost-full flag.
// Optional sticky OVERFLOW/UNDERFLOW flags are built when FIFO_N_ERROR_CHECK_EN is defined.
module fifo_n import fifo_pkg::*; #(
    parameter int width        = 32,
    parameter int depth        = 4,
    parameter int afull_thresh = 1,
    parameter int guarded      = 1
) (
    input  logic     CLK,
    input  logic     RST,
    fifo_n_if.slave  q
);
    localparam int             cw       = fifo_cnt_w(depth);
    localparam int             pw       = fifo_ptr_w(depth);
    localparam logic [cw-1:0]  full_c   = cw'(depth);
    localparam logic [cw-1:0]  thresh_c = cw'(afull_thresh);
    localparam logic [pw-1:0]  last_c   = pw'(depth - 1);
    localparam bit             chk      = (guarded != 0);

    logic [width-1:0] mem [depth];
    logic [width-1:0] head;
    logic [cw-1:0]    count;
    logic [pw-1:0]    rd_ptr;
    logic [pw-1:0]    wr_ptr;
    logic [pw-1:0]    rd_nxt;
    logic             is_full;
    logic             is_empty;
    logic             enq_ok;
    logic             deq_ok;

    assign is_full  = (count == full_c);
    assign is_empty = (count == '0);

    // A full FIFO may still accept ENQ when DEQ frees the head slot on the same edge.
    assign deq_ok = q.DEQ && !q.CLR && (!chk || !is_empty);
    assign enq_ok = q.ENQ && !q.CLR && (!chk || !is_full || q.DEQ);

    assign rd_nxt = (rd_ptr == last_c) ? '0 : rd_ptr + pw'(1);

    fifo_n_ptr #(.depth(depth)) u_wr_ptr (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (q.CLR),
        .inc   (enq_ok),
        .ptr   (wr_ptr)
    );

    fifo_n_ptr #(.depth(depth)) u_rd_ptr (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (q.CLR),
        .inc   (deq_ok),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge CLK) begin
        if (enq_ok) begin
            mem[wr_ptr] <= q.D_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (q.CLR) begin
            count <= '0;
        end else if (enq_ok && !deq_ok) begin
            count <= count + cw'(1);
        end else if (deq_ok && !enq_ok) begin
            count <= count - cw'(1);
        end
    end

    // Head mirrors mem[rd_ptr]; the incoming word goes straight to it when it becomes the head.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            head <= '0;
        end else if (!q.CLR) begin
            if (deq_ok && (count > cw'(1))) begin
                head <= mem[rd_nxt];
            end else if (enq_ok && (is_empty || (deq_ok && count == cw'(1)))) begin
                head <= q.D_IN;
            end
        end
    end

    assign q.FULL_N        = !is_full;
    assign q.EMPTY_N       = !is_empty;
    assign q.COUNT         = count;
    assign q.D_OUT         = head;
    assign q.ALMOST_FULL_N = ((full_c - count) > thresh_c);

`ifdef FIFO_N_ERROR_CHECK_EN
    logic ovf_ev;
    logic udf_ev;
    logic ovf_q;
    logic udf_q;

    assign ovf_ev = chk && q.ENQ && !q.DEQ && !q.CLR && is_full;
    assign udf_ev = chk && q.DEQ && !q.CLR && is_empty;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (q.CLR) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q | ovf_ev;
            udf_q <= udf_q | udf_ev;
        end
    end

    assign q.OVERFLOW  = ovf_q;
    assign q.UNDERFLOW = udf_q;

`ifndef SYNTHESIS
    always @(posedge CLK) begin
        if (RST && ovf_ev) $error("fifo_n: enqueue dropped while full");
        if (RST && udf_ev) $error("fifo_n: dequeue dropped while empty");
    end
`endif
`endif

endmodule

// File: tb/tb_fifo_n.sv
// Self-checking bench for fifo_n: depth-4 and depth-3 instances against a queue reference model.
module tb_fifo_n;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fifo_n_if #(.width(8), .depth(4)) if4 ();
  fifo_n_if #(.width(8), .depth(3)) if3 ();

  fifo_n #(.width(8), .depth(4), .afull_thresh(1), .guarded(1)) u4 (
    .CLK (clk),
    .RST (rst_n),
    .q   (if4)
  );

  fifo_n #(.width(8), .depth(3), .afull_thresh(1), .guarded(1)) u3 (
    .CLK (clk),
    .RST (rst_n),
    .q   (if3)
  );

  // reference model: queue contents plus the last head value seen on D_OUT
  logic [7:0] m4[$];
  logic [7:0] m3[$];
  logic [7:0] h4;
  logic [7:0] h3;
  bit         of4, uf4, of3, uf3;

  initial begin
    #500000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m4.delete(); m3.delete();
    h4 = 8'h00; h3 = 8'h00;
    of4 = 0; uf4 = 0; of3 = 0; uf3 = 0;
  endtask

  task automatic check4(input string tag);
    int n;
    n = m4.size();
    chk({tag, ".count4"}, 32'(if4.COUNT), 32'(n));
    chk({tag, ".full_n4"}, 32'(if4.FULL_N), 32'(n != 4));
    chk({tag, ".empty_n4"}, 32'(if4.EMPTY_N), 32'(n != 0));
    chk({tag, ".afull_n4"}, 32'(if4.ALMOST_FULL_N), 32'((4 - n) > 1));
    chk({tag, ".dout4"}, 32'(if4.D_OUT), 32'(h4));
`ifdef FIFO_N_ERROR_CHECK_EN
    chk({tag, ".ovf4"}, 32'(if4.OVERFLOW), 32'(of4));
    chk({tag, ".udf4"}, 32'(if4.UNDERFLOW), 32'(uf4));
`endif
  endtask

  task automatic check3(input string tag);
    int n;
    n = m3.size();
    chk({tag, ".count3"}, 32'(if3.COUNT), 32'(n));
    chk({tag, ".full_n3"}, 32'(if3.FULL_N), 32'(n != 3));
    chk({tag, ".empty_n3"}, 32'(if3.EMPTY_N), 32'(n != 0));
    chk({tag, ".afull_n3"}, 32'(if3.ALMOST_FULL_N), 32'((3 - n) > 1));
    chk({tag, ".dout3"}, 32'(if3.D_OUT), 32'(h3));
`ifdef FIFO_N_ERROR_CHECK_EN
    chk({tag, ".ovf3"}, 32'(if3.OVERFLOW), 32'(of3));
    chk({tag, ".udf3"}, 32'(if3.UNDERFLOW), 32'(uf3));
`endif
  endtask

  task automatic step4(input bit enq, input bit deq, input bit clr, input logic [7:0] din,
                       input string tag);
    bit dok, eok;
    if4.ENQ = enq; if4.DEQ = deq; if4.CLR = clr; if4.D_IN = din;
    @(posedge clk);
    if (clr) begin
      m4.delete(); of4 = 0; uf4 = 0;
    end else begin
      if (enq && !deq && m4.size() == 4) of4 = 1;
      if (deq && m4.size() == 0) uf4 = 1;
      dok = deq && (m4.size() > 0);
      eok = enq && ((m4.size() < 4) || dok);
      if (dok) void'(m4.pop_front());
      if (eok) m4.push_back(din);
      if (m4.size() > 0) h4 = m4[0];
    end
    #1;
    if4.ENQ = 0; if4.DEQ = 0; if4.CLR = 0;
    check4(tag);
  endtask

  task automatic step3(input bit enq, input bit deq, input bit clr, input logic [7:0] din,
                       input string tag);
    bit dok, eok;
    if3.ENQ = enq; if3.DEQ = deq; if3.CLR = clr; if3.D_IN = din;
    @(posedge clk);
    if (clr) begin
      m3.delete(); of3 = 0; uf3 = 0;
    end else begin
      if (enq && !deq && m3.size() == 3) of3 = 1;
      if (deq && m3.size() == 0) uf3 = 1;
      dok = deq && (m3.size() > 0);
      eok = enq && ((m3.size() < 3) || dok);
      if (dok) void'(m3.pop_front());
      if (eok) m3.push_back(din);
      if (m3.size() > 0) h3 = m3[0];
    end
    #1;
    if3.ENQ = 0; if3.DEQ = 0; if3.CLR = 0;
    check3(tag);
  endtask

  initial begin
    logic [7:0] v;
    int chunks[5] = '{1, 2, 3, 3, 1};

    // clock/reset
    if4.ENQ = 0; if4.DEQ = 0; if4.CLR = 0; if4.D_IN = '0;
    if3.ENQ = 0; if3.DEQ = 0; if3.CLR = 0; if3.D_IN = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check4("reset");
    check3("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // fill, dropped fifth ENQ, drain, dropped DEQ on empty
    step4(1, 0, 0, 8'h11, "fill1");
    step4(1, 0, 0, 8'h22, "fill2");
    step4(1, 0, 0, 8'h33, "fill3");
    step4(1, 0, 0, 8'h44, "fill4");
    step4(1, 0, 0, 8'h55, "fill5_drop");
    for (int i = 0; i < 4; i++) step4(0, 1, 0, 8'h00, "drain");
    step4(0, 1, 0, 8'h00, "deq_empty");
`ifdef FIFO_N_ERROR_CHECK_EN
    chk("udf_set", 32'(if4.UNDERFLOW), 32'd1);
    chk("udf_count0", 32'(if4.COUNT), 32'd0);
    step4(0, 0, 1, 8'h00, "clr_udf");
`endif

    // full with simultaneous ENQ+DEQ, then drain ending in 0xAA
    for (int i = 1; i <= 4; i++) step4(1, 0, 0, 8'(i), "refill");
`ifdef FIFO_N_ERROR_CHECK_EN
    step4(1, 0, 0, 8'h5A, "ovf");
    chk("ovf_set", 32'(if4.OVERFLOW), 32'd1);
`endif
    step4(1, 1, 0, 8'hAA, "full_enq_deq");
    for (int i = 0; i < 4; i++) step4(0, 1, 0, 8'h00, "drain_aa");
    chk("last_aa", 32'(if4.D_OUT), 32'h0000_00AA);

    // simultaneous ENQ+DEQ while empty: only the ENQ happens
    step4(1, 1, 0, 8'hC3, "empty_enq_deq");
    step4(0, 1, 0, 8'h00, "empty_enq_deq_drain");

    // CLR with ENQ asserted at COUNT=2, then ENQ 0x77
    step4(1, 0, 0, 8'h61, "pre_clr1");
    step4(1, 0, 0, 8'h62, "pre_clr2");
    step4(1, 0, 1, 8'h63, "clr_with_enq");
    chk("clr_count", 32'(if4.COUNT), 32'd0);
`ifdef FIFO_N_ERROR_CHECK_EN
    chk("clr_ovf", 32'(if4.OVERFLOW), 32'd0);
    chk("clr_udf", 32'(if4.UNDERFLOW), 32'd0);
`endif
    step4(1, 0, 0, 8'h77, "post_clr_enq");
    chk("post_clr_dout", 32'(if4.D_OUT), 32'h0000_0077);

    // depth-3 wrap-around, interleaved bursts
    v = 8'h30;
    foreach (chunks[c]) begin
      for (int i = 0; i < chunks[c]; i++) begin
        step3(1, 0, 0, v, "wrap_in");
        chk("wrap_max", 32'(if3.COUNT <= 3), 32'd1);
        v = v + 8'd1;
      end
      for (int i = 0; i < chunks[c]; i++) step3(0, 1, 0, 8'h00, "wrap_out");
    end

    // randomized traffic on both instances
    for (int i = 0; i < 400; i++) begin
      step4(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0, 8'($urandom), "rand4");
      step3(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 31) == 0, 8'($urandom), "rand3");
    end

    // reset mid-cycle with an ENQ in flight
    step4(1, 0, 0, 8'hE1, "pre_rst");
    if4.ENQ = 1; if4.D_IN = 8'hE2;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check4("mid_rst");
    check3("mid_rst");
    @(negedge clk);
    if4.ENQ = 0;
    rst_n = 1'b1;
    step4(0, 0, 0, 8'h00, "after_rst");
    step3(0, 0, 0, 8'h00, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
